// File: rtl/bench_sequencer.sv
// Slot sequencer for the benchmark wrapper: drives the output-mux select and a
// shared sub-design reset, either following manual_sel or sweeping enabled slots.
module bench_sequencer #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 auto_en,
  input  logic [SEL_W-1:0]     manual_sel,
  input  logic                 start,
  input  logic                 loop_en,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [NUM_SLOTS-1:0] skip_mask,
  output logic [SEL_W-1:0]     sel,
  output logic                 sub_reset_n,
  output logic                 busy,
  output logic                 slot_tick,
  output logic                 sweep_done
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [SEL_W-1:0] MAX_SLOT = SEL_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               auto_q, auto_d;
  logic               slot_tick_d, sweep_done_d;
  logic               lo_found, nx_found;
  logic [SEL_W-1:0]   lo_slot, nx_slot, man_slot;

  // Lowest enabled slot, and the next enabled slot above the current one.
  always_comb begin
    lo_found = 1'b0;
    lo_slot  = '0;
    nx_found = 1'b0;
    nx_slot  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!skip_mask[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_slot  = SEL_W'(i);
      end
      if (!skip_mask[i] && !nx_found && (i > 32'(sel))) begin
        nx_found = 1'b1;
        nx_slot  = SEL_W'(i);
      end
    end
  end

  assign man_slot = (32'(manual_sel) >= NUM_SLOTS) ? MAX_SLOT : manual_sel;

  // Next-state logic; all outputs are registered from these _d values.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel;
    rst_cnt_d    = rst_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    auto_d       = auto_q;
    slot_tick_d  = 1'b0;
    sweep_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (auto_en) begin
          if (start) begin
            if (lo_found) begin
              sel_d     = lo_slot;
              state_d   = SWITCH;
              rst_cnt_d = RST_LOAD;
              auto_d    = 1'b1;
            end else begin
              sweep_done_d = 1'b1;
            end
          end
        end else if (man_slot != sel) begin
          sel_d     = man_slot;
          state_d   = SWITCH;
          rst_cnt_d = RST_LOAD;
          auto_d    = 1'b0;
        end
      end
      SWITCH: begin
        if (auto_q && !auto_en) begin
          state_d = IDLE;
        end else if (rst_cnt_q == '0) begin
          if (auto_q) begin
            state_d     = RUN;
            slot_tick_d = 1'b1;
            dwell_cnt_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      RUN: begin
        if (!auto_en) begin
          state_d = IDLE;
        end else if (dwell_cnt_q == '0) begin
          if (nx_found) begin
            sel_d     = nx_slot;
            state_d   = SWITCH;
            rst_cnt_d = RST_LOAD;
          end else if (loop_en && lo_found) begin
            sel_d     = lo_slot;
            state_d   = SWITCH;
            rst_cnt_d = RST_LOAD;
          end else begin
            state_d      = IDLE;
            sweep_done_d = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel         <= '0;
      rst_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      auto_q      <= 1'b0;
      sub_reset_n <= 1'b0;
      busy        <= 1'b0;
      slot_tick   <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      rst_cnt_q   <= rst_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      auto_q      <= auto_d;
      sub_reset_n <= (state_d != SWITCH);
      busy        <= (state_d != IDLE);
      slot_tick   <= slot_tick_d;
      sweep_done  <= sweep_done_d;
    end
  end

endmodule

// File: tb/tb_bench_sequencer.sv
// Cycle-exact scoreboard bench for bench_sequencer: each driven cycle pushes the
// expected {sel, sub_reset_n, busy, slot_tick, sweep_done} and pops it after the edge.
module tb_bench_sequencer;

  localparam int unsigned RST_CYCLES = 2;

  logic       clk;
  logic       reset_n;
  logic       auto_en;
  logic [2:0] manual_sel;
  logic       start;
  logic       loop_en;
  logic [7:0] dwell;
  logic [7:0] skip_mask;
  logic [2:0] sel;
  logic       sub_reset_n;
  logic       busy;
  logic       slot_tick;
  logic       sweep_done;

  logic [6:0] obs;
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  string      phase = "init";

  assign obs = {sel, sub_reset_n, busy, slot_tick, sweep_done};

  bench_sequencer #(
    .NUM_SLOTS(8), .SEL_W(3), .DWELL_W(8), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .auto_en    (auto_en),
    .manual_sel (manual_sel),
    .start      (start),
    .loop_en    (loop_en),
    .dwell      (dwell),
    .skip_mask  (skip_mask),
    .sel        (sel),
    .sub_reset_n(sub_reset_n),
    .busy       (busy),
    .slot_tick  (slot_tick),
    .sweep_done (sweep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: {sel,srn,busy,tick,done} got %b_%b%b%b%b expected %b_%b%b%b%b",
               tag, $time, got[6:4], got[3], got[2], got[1], got[0],
               want[6:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // One clock: start is a single-cycle pulse, then pop and compare.
  task automatic cyc();
    logic [6:0] e;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(phase, obs, e);
    end
  endtask

  task automatic exp_cyc(input logic [2:0] s, input logic srn, input logic b,
                         input logic t, input logic d);
    exp_q.push_back({s, srn, b, t, d});
    cyc();
  endtask

  // One auto-mode slot visit: reset pulse, tick on RUN entry, rest of dwell.
  task automatic run_slot(input logic [2:0] s, input int d);
    for (int k = 0; k < int'(RST_CYCLES); k++) exp_cyc(s, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(s, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < d; k++) exp_cyc(s, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] seq4 [5];
    seq4 = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd1};

    reset_n    = 1'b0;
    auto_en    = 1'b0;
    manual_sel = 3'd0;
    start      = 1'b0;
    loop_en    = 1'b0;
    dwell      = 8'd0;
    skip_mask  = 8'h00;

    phase = "reset_values";
    #2;
    check(phase, obs, 7'b000_0000);
    exp_cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase = "reset_release";
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "manual_0_to_5";
    manual_sel = 3'd5;
    exp_cyc(3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    phase = "manual_same";
    for (int k = 0; k < 3; k++) exp_cyc(3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "manual_change_in_switch";
    manual_sel = 3'd2;
    exp_cyc(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    manual_sel = 3'd6;
    exp_cyc(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "auto_full_sweep";
    dwell     = 8'd3;
    skip_mask = 8'h00;
    loop_en   = 1'b0;
    auto_en   = 1'b1;
    start     = 1'b1;
    for (int s = 0; s < 8; s++) run_slot(3'(s), 3);
    phase = "auto_sweep_done";
    exp_cyc(3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_cyc(3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "auto_loop_masked";
    skip_mask = 8'b1010_0101;
    dwell     = 8'd0;
    loop_en   = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 5; i++) run_slot(seq4[i], 1);
    phase = "abort_in_switch";
    exp_cyc(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    auto_en    = 1'b0;
    manual_sel = 3'd3;
    exp_cyc(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "all_skipped";
    skip_mask = 8'hFF;
    auto_en   = 1'b1;
    start     = 1'b1;
    exp_cyc(3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_cyc(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "abort_in_run";
    skip_mask = 8'h03;
    dwell     = 8'd4;
    loop_en   = 1'b0;
    start     = 1'b1;
    exp_cyc(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cyc(3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    dwell = 8'd1;
    exp_cyc(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    auto_en    = 1'b0;
    manual_sel = 3'd2;
    exp_cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "reset_mid_switch";
    skip_mask = 8'h0F;
    auto_en   = 1'b1;
    start     = 1'b1;
    exp_cyc(3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs, 7'b000_0000);
    auto_en    = 1'b0;
    manual_sel = 3'd0;
    exp_cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    phase = "post_reset";
    exp_cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
